// File: rtl/sobel_grad_sq.sv
// Streaming 3x3 Sobel front end: raster pixels in, saturated (Gx^2+Gy^2)>>SHIFT out.
// Two line buffers supply rows r-1/r-2; a 3-stage pipeline gives fixed 3-cycle latency.
module sobel_grad_sq #(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int SHIFT = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sof,
  input  logic        pix_valid,
  input  logic [7:0]  pix_in,
  output logic        r_valid,
  output logic [15:0] r_out,
  output logic        r_eof
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0] col, cur_col;
  logic [RW-1:0] row, cur_row;
  logic          col_last, row_last, win_done, win_eof;

  logic [7:0] lb1 [IMG_W];
  logic [7:0] lb2 [IMG_W];
  logic [7:0] top, mid, bot;
  logic [7:0] t0, m0, b0, t1, m1, b1;

  logic [9:0]         lsum, rsum, tsum, bsum;
  logic signed [10:0] gx, gy;

  logic               v1, e1, v2, e2;
  logic signed [10:0] gx_q, gy_q;
  logic [10:0]        ax, ay;
  logic [19:0]        sq_x, sq_y;
  logic [20:0]        sum, shifted;
  logic [15:0]        sat;

  // sof relabels the current pixel as (0,0) so it can restart mid-frame
  assign cur_col  = sof ? '0 : col;
  assign cur_row  = sof ? '0 : row;
  assign col_last = (cur_col == CW'(IMG_W - 1));
  assign row_last = (cur_row == RW'(IMG_H - 1));
  assign win_done = pix_valid && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
  assign win_eof  = col_last && row_last;

  // Right-hand window column arrives this cycle; left two are registered
  assign top = lb2[cur_col];
  assign mid = lb1[cur_col];
  assign bot = pix_in;

  assign lsum = {2'b0, t0} + {1'b0, m0, 1'b0} + {2'b0, b0};
  assign rsum = {2'b0, top} + {1'b0, mid, 1'b0} + {2'b0, bot};
  assign tsum = {2'b0, t0} + {1'b0, t1, 1'b0} + {2'b0, top};
  assign bsum = {2'b0, b0} + {1'b0, b1, 1'b0} + {2'b0, bot};
  assign gx   = $signed({1'b0, rsum}) - $signed({1'b0, lsum});
  assign gy   = $signed({1'b0, bsum}) - $signed({1'b0, tsum});

  assign ax = gx_q[10] ? 11'(-gx_q) : gx_q;
  assign ay = gy_q[10] ? 11'(-gy_q) : gy_q;

  assign sum     = {1'b0, sq_x} + {1'b0, sq_y};
  assign shifted = sum >> SHIFT;
  assign sat     = (shifted > 21'd65535) ? 16'hFFFF : shifted[15:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (pix_valid) begin
      col <= col_last ? '0 : cur_col + CW'(1);
      if (col_last) row <= row_last ? '0 : cur_row + RW'(1);
      else          row <= cur_row;
    end
  end

  // Line buffers and window columns are data only; the counters gate their use
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb1[cur_col] <= pix_in;
      lb2[cur_col] <= lb1[cur_col];
      t0 <= t1;  m0 <= m1;  b0 <= b1;
      t1 <= top; m1 <= mid; b1 <= bot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1      <= 1'b0;
      e1      <= 1'b0;
      gx_q    <= '0;
      gy_q    <= '0;
      v2      <= 1'b0;
      e2      <= 1'b0;
      sq_x    <= '0;
      sq_y    <= '0;
      r_valid <= 1'b0;
      r_eof   <= 1'b0;
      r_out   <= '0;
    end else begin
      v1      <= win_done;
      e1      <= win_done && win_eof;
      gx_q    <= gx;
      gy_q    <= gy;
      v2      <= v1;
      e2      <= e1;
      sq_x    <= {10'b0, ax[9:0]} * {10'b0, ax[9:0]};
      sq_y    <= {10'b0, ay[9:0]} * {10'b0, ay[9:0]};
      r_valid <= v2;
      r_eof   <= v2 && e2;
      if (v2) r_out <= sat;
    end
  end
endmodule

// File: tb/tb_sobel_grad_sq.sv
// Scoreboard bench for sobel_grad_sq on an 8x8 frame: driver pushes expected windows,
// a negedge monitor pops and checks value, eof flag and 3-cycle latency.
module tb_sobel_grad_sq;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int SH = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sof = 1'b0;
  logic        pix_valid = 1'b0;
  logic [7:0]  pix_in = '0;
  logic        r_valid;
  logic [15:0] r_out;
  logic        r_eof;

  sobel_grad_sq #(.IMG_W(W), .IMG_H(H), .SHIFT(SH)) dut (
    .clk(clk), .rst_n(rst_n), .sof(sof), .pix_valid(pix_valid), .pix_in(pix_in),
    .r_valid(r_valid), .r_out(r_out), .r_eof(r_eof)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [15:0] val; logic eof; int issue; } exp_t;
  exp_t q[$];
  exp_t e;

  int total = 0;
  int bad = 0;
  int pulses, eofs, last_eof_idx, n_step;
  logic [15:0] last_val;
  logic [15:0] seq[$];
  logic [15:0] seqa[$];
  logic        rec_seq = 1'b0;

  logic [7:0] img [H][W];

  function automatic int px(int r, int c);
    return int'(img[r][c]);
  endfunction

  // Completing pixel (r,c); window covers rows r-2..r, cols c-2..c
  function automatic logic [15:0] model(int r, int c);
    int gx, gy, s;
    gx = (px(r-2,c) + 2*px(r-1,c) + px(r,c)) - (px(r-2,c-2) + 2*px(r-1,c-2) + px(r,c-2));
    gy = (px(r,c-2) + 2*px(r,c-1) + px(r,c)) - (px(r-2,c-2) + 2*px(r-2,c-1) + px(r-2,c));
    s = (gx*gx + gy*gy) >> SH;
    if (s > 65535) s = 65535;
    return 16'(s);
  endfunction

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", name, got, want);
    end
  endtask

  task automatic clear_stats();
    pulses = 0; eofs = 0; last_eof_idx = 0; n_step = 0; last_val = '0;
  endtask

  always @(negedge clk) begin
    if (rst_n && r_valid) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL spurious_valid got r_out=%0d expected no output", r_out);
      end else begin
        e = q.pop_front();
        if (r_out !== e.val || r_eof !== e.eof || (cyc - e.issue) != 3) begin
          bad++;
          $display("FAIL window got r_out=%0d eof=%0b lat=%0d expected r_out=%0d eof=%0b lat=3",
                   r_out, r_eof, cyc - e.issue, e.val, e.eof);
        end
      end
      pulses++;
      if (r_eof) begin eofs++; last_eof_idx = pulses; end
      last_val = r_out;
      if (r_out == 16'd32512) n_step++;
      if (rec_seq) seq.push_back(r_out);
    end
  end

  task automatic send_frame(input int count, input bit gaps);
    int r, c;
    for (int k = 0; k < count && k < W*H; k++) begin
      r = k / W;
      c = k % W;
      if (gaps && $urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
        pix_valid = 1'b0; sof = 1'b0;
      end
      @(posedge clk); #1;
      pix_valid = 1'b1;
      sof = (k == 0);
      pix_in = img[r][c];
      if (r >= 2 && c >= 2) q.push_back('{model(r, c), (r == H-1 && c == W-1), cyc});
    end
    @(posedge clk); #1;
    pix_valid = 1'b0; sof = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    chk({name, "_drain_left"}, q.size(), 0);
    q.delete();
  endtask

  task automatic fill_rand();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    #1;
    chk("reset_r_valid", int'(r_valid), 0);
    chk("reset_r_out", int'(r_out), 0);
    chk("reset_r_eof", int'(r_eof), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Flat frame
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 8'd128;
    clear_stats();
    send_frame(W*H, 1'b0);
    drain("flat");
    chk("flat_pulses", pulses, 36);
    chk("flat_eofs", eofs, 1);
    chk("flat_eof_idx", last_eof_idx, 36);
    chk("flat_last_val", int'(last_val), 0);

    // Vertical step: centres on col 3 and 4 see Gx=1020
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = (c >= 4) ? 8'd255 : 8'd0;
    clear_stats();
    send_frame(W*H, 1'b0);
    drain("step");
    chk("step_count_32512", n_step, 12);
    chk("step_pulses", pulses, 36);

    // Corner: last window Gx=Gy=765
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++)
      img[r][c] = (r == H-1 || c == W-1) ? 8'd255 : 8'd0;
    clear_stats();
    send_frame(W*H, 1'b0);
    drain("corner");
    chk("corner_last_val", int'(last_val), 36576);

    // Continuous vs gapped input must give the same sequence
    fill_rand();
    clear_stats();
    seq.delete();
    rec_seq = 1'b1;
    send_frame(W*H, 1'b0);
    drain("cont");
    seqa = seq;
    seq.delete();
    send_frame(W*H, 1'b1);
    drain("gaps");
    rec_seq = 1'b0;
    chk("cont_len", seqa.size(), 36);
    chk("gaps_len", seq.size(), 36);
    for (int i = 0; i < 36 && i < seq.size() && i < seqa.size(); i++)
      chk("gap_seq_match", int'(seq[i]), int'(seqa[i]));

    // sof at pixel (4,5) restarts the frame; old partial windows still drain
    fill_rand();
    clear_stats();
    send_frame(4*W + 5, 1'b0);
    fill_rand();
    send_frame(W*H, 1'b0);
    drain("sof_restart");
    chk("sof_pulses", pulses, 15 + 36);
    chk("sof_eofs", eofs, 1);

    // Async reset mid-frame with windows in flight
    fill_rand();
    send_frame(3*W + 4, 1'b0);
    #2 rst_n = 1'b0;
    q.delete();
    #1;
    chk("arst_r_valid", int'(r_valid), 0);
    chk("arst_r_out", int'(r_out), 0);
    chk("arst_r_eof", int'(r_eof), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    fill_rand();
    clear_stats();
    send_frame(W*H, 1'b0);
    drain("post_reset");
    chk("post_reset_pulses", pulses, 36);
    chk("post_reset_eofs", eofs, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
